// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter and its busy table.
package wb_arbiter_pkg;

    localparam int   AW_DEF     = 5;
    localparam int   DW_DEF     = 32;
    localparam logic RST_ACTIVE = 1'b1;
    localparam logic EN_ON      = 1'b1;
    localparam logic EN_OFF     = 1'b0;

    typedef enum logic {
        SRC_EX  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // Zero-filled word of any width, used for reset and x0 comparisons.
    function automatic logic [63:0] zero_word();
        return '0;
    endfunction

endpackage

// File: rtl/busy_table.sv
// Scoreboard of registers with an outstanding write: one bit per register, x0 never busy.
module busy_table
    import wb_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] raddr3,
    output logic          busy1,
    output logic          busy2,
    output logic          busy3
);
    localparam int N = 1 << AW;

    logic [N-1:0] busy;

    // Set is applied after clear so a same-edge reservation of the retiring
    // register keeps it busy for the new producer.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            busy <= '0;
        end else begin
            if (clr_en == EN_ON) busy[clr_addr] <= 1'b0;
            if (set_en == EN_ON) busy[set_addr] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    assign busy1 = (raddr1 == '0) ? 1'b0 : busy[raddr1];
    assign busy2 = (raddr2 == '0) ? 1'b0 : busy[raddr2];
    assign busy3 = (raddr3 == '0) ? 1'b0 : busy[raddr3];

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter between execute and load results, with
// destination-register busy tracking for issue hazard checks.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          ex_valid,
    input  logic [AW-1:0] ex_waddr,
    input  logic [DW-1:0] ex_wdata,
    output logic          ex_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_ready,
    input  logic [AW-1:0] q_raddr1,
    input  logic [AW-1:0] q_raddr2,
    output logic          q_busy1,
    output logic          q_busy2,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);
    src_e          ptr;
    logic          active;
    logic          acc;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;
    logic          wr_hit;
    logic          iss_hit;
    logic          set_en;
    logic          b1, b2, b_iss;

    assign active    = (rst != RST_ACTIVE) && rdy;
    assign ex_ready  = active && ex_valid  && (!mem_valid || ptr == SRC_EX);
    assign mem_ready = active && mem_valid && (!ex_valid  || ptr == SRC_MEM);

    assign acc      = ex_ready || mem_ready;
    assign acc_addr = ex_ready ? ex_waddr : mem_waddr;
    assign acc_data = ex_ready ? ex_wdata : mem_wdata;
    assign wr_hit   = acc && (acc_addr != '0);

    // A write retiring iss_rd this cycle frees it for a new reservation.
    assign iss_hit   = wr_hit && (acc_addr == iss_rd);
    assign iss_ready = active && ((iss_rd == '0) || !b_iss || iss_hit);
    assign set_en    = iss_valid && iss_ready && (iss_rd != '0);

    assign q_busy1 = (rst != RST_ACTIVE) && b1;
    assign q_busy2 = (rst != RST_ACTIVE) && b2;

    busy_table #(.AW(AW)) u_busy (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (iss_rd),
        .clr_en   (wr_hit),
        .clr_addr (acc_addr),
        .raddr1   (q_raddr1),
        .raddr2   (q_raddr2),
        .raddr3   (iss_rd),
        .busy1    (b1),
        .busy2    (b2),
        .busy3    (b_iss)
    );

    // Pointer moves only on contended grants; it then favours the loser.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            we    <= EN_OFF;
            waddr <= '0;
            wdata <= '0;
            ptr   <= SRC_EX;
        end else begin
            we <= wr_hit;
            if (acc) begin
                waddr <= acc_addr;
                wdata <= acc_data;
            end
            if (ex_valid && mem_valid && acc)
                ptr <= ex_ready ? SRC_MEM : SRC_EX;
        end
    end

endmodule
